// File: rtl/synch_up_count_tff_pkg.sv
// Shared definitions for the synchronous T-flip-flop counter family.
//   default_modulus(width) : full binary count length, 2**width
//   TFF_RST_VAL            : value every T flip-flop takes while reset is high
package synch_up_count_tff_pkg;

  localparam logic TFF_RST_VAL = 1'b0;

  function automatic int default_modulus(input int width);
    return 2 ** width;
  endfunction

endpackage

// File: rtl/synch_up_count_tff_t_ff_ar.sv
// T flip-flop with asynchronous active-high reset.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active high, forces q to TFF_RST_VAL
//   t    : toggle enable, sampled on the rising edge
//   q    : stored bit
//   qbar : complement of q
module t_ff_ar
  import synch_up_count_tff_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q,
  output logic qbar
);

  logic state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= TFF_RST_VAL;
    end else if (t) begin
      state <= ~state;
    end
  end

  assign q    = state;
  assign qbar = ~state;

endmodule

// File: rtl/synch_up_count_tff.sv
// Synchronous, cascadable modulo-MODULUS up counter built from T flip-flops.
// Every bit is stored in a t_ff_ar instance; this module only forms the toggle
// vector and decodes terminal count / carry.
// Parameters:
//   WIDTH   : counter width (>= 1)
//   MODULUS : count length, 2 <= MODULUS <= 2**WIDTH; sequence 0..MODULUS-1
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active high (q -> 0)
//   en   : count enable
//   load : synchronous parallel load, wins over en
//   d    : load value (values >= MODULUS are accepted and recover on next count)
//   q    : count value
//   qbar : ~q
//   tc   : terminal count, q == MODULUS-1 (combinational)
//   co   : carry out, tc & en & ~load (combinational); feeds en of next stage
module synch_up_count_tff
  import synch_up_count_tff_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = default_modulus(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             co
);

  localparam logic [WIDTH-1:0] TERM      = WIDTH'(MODULUS - 1);
  localparam bit               IS_BINARY = (MODULUS == default_modulus(WIDTH));

  logic [WIDTH-1:0] t;

  generate
    if (IS_BINARY) begin : g_binary
      // Classic synchronous T-chain: bit i toggles when all lower bits are 1.
      logic [WIDTH-1:0] chain;

      always_comb begin
        chain    = '1;
        chain[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
          chain[i] = chain[i-1] & q[i-1];
        end
      end

      always_comb begin
        t = '0;
        if (load) begin
          t = q ^ d;
        end else if (en) begin
          t = chain;
        end
      end
    end else begin : g_modulo
      // Toggle exactly the bits that differ from the wanted next value; the
      // wrap to 0 then becomes a toggle of every set bit. Using >= lets an
      // out-of-range loaded value fall back to 0 on the next count.
      logic [WIDTH-1:0] next_q;

      always_comb begin
        next_q = q;
        if (load) begin
          next_q = d;
        end else if (en) begin
          next_q = (q >= TERM) ? '0 : q + WIDTH'(1);
        end
      end

      assign t = q ^ next_q;
    end
  endgenerate

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    t_ff_ar u_tff (
      .clk  (clk),
      .rst  (rst),
      .t    (t[i]),
      .q    (q[i]),
      .qbar (qbar[i])
    );
  end

  assign tc = (q == TERM);
  assign co = tc & en & ~load;

endmodule

// File: tb/tb_synch_up_count_tff.sv
// Directed bench for synch_up_count_tff: binary (16), decade (10) and a
// two-stage cascade of binary counters.
module tb_synch_up_count_tff;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Binary stage, WIDTH=4, MODULUS=16
  logic       b_rst, b_en, b_load;
  logic [3:0] b_d, b_q, b_qbar;
  logic       b_tc, b_co;

  // Decade stage, WIDTH=4, MODULUS=10
  logic       m_rst, m_en, m_load;
  logic [3:0] m_d, m_q, m_qbar;
  logic       m_tc, m_co;

  // Cascade: lower stage co drives upper stage en
  logic       c_rst, c_en, c_load;
  logic [3:0] c_d;
  logic [3:0] c_lo_q, c_lo_qbar, c_hi_q, c_hi_qbar;
  logic       c_lo_tc, c_lo_co, c_hi_tc, c_hi_co;

  synch_up_count_tff #(.WIDTH(4), .MODULUS(16)) u_bin (
    .clk(clk), .rst(b_rst), .en(b_en), .load(b_load), .d(b_d),
    .q(b_q), .qbar(b_qbar), .tc(b_tc), .co(b_co)
  );

  synch_up_count_tff #(.WIDTH(4), .MODULUS(10)) u_dec (
    .clk(clk), .rst(m_rst), .en(m_en), .load(m_load), .d(m_d),
    .q(m_q), .qbar(m_qbar), .tc(m_tc), .co(m_co)
  );

  synch_up_count_tff #(.WIDTH(4)) u_lo (
    .clk(clk), .rst(c_rst), .en(c_en), .load(c_load), .d(c_d),
    .q(c_lo_q), .qbar(c_lo_qbar), .tc(c_lo_tc), .co(c_lo_co)
  );

  synch_up_count_tff #(.WIDTH(4)) u_hi (
    .clk(clk), .rst(c_rst), .en(c_lo_co), .load(c_load), .d(c_d),
    .q(c_hi_q), .qbar(c_hi_qbar), .tc(c_hi_tc), .co(c_hi_co)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp;

    b_rst = 1'b1; b_en = 1'b0; b_load = 1'b0; b_d = 4'h0;
    m_rst = 1'b1; m_en = 1'b0; m_load = 1'b0; m_d = 4'h0;
    c_rst = 1'b1; c_en = 1'b0; c_load = 1'b0; c_d = 4'h0;
    #2;
    b_en = 1'b1;
    #1;
    check("rst_q",    b_q,    4'h0);
    check("rst_qbar", b_qbar, 4'hf);
    check("rst_tc",   b_tc,   1'b0);
    check("rst_co",   b_co,   1'b0);
    check("rst_dec_q", m_q,   4'h0);
    b_en = 1'b0;
    @(negedge clk);
    b_rst = 1'b0; m_rst = 1'b0; c_rst = 1'b0;

    // ---- binary: count a little, then reset asynchronously mid-cycle
    b_en = 1'b1;
    tick(); tick(); tick();
    check("bin_count3", b_q, 4'h3);
    @(negedge clk);
    b_rst = 1'b1;
    #1;
    check("async_rst_q",    b_q,    4'h0);
    check("async_rst_qbar", b_qbar, 4'hf);
    check("async_rst_co",   b_co,   1'b0);
    #11;
    b_rst = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      check("post_rst_count", b_q, i);
    end
    check("post_rst_tc", b_tc, 1'b1);
    check("post_rst_co", b_co, 1'b1);
    check("post_rst_qbar", b_qbar, 4'h0);

    // ---- binary wrap: 17 edges from 0
    @(negedge clk);
    b_rst = 1'b1;
    #1;
    b_rst = 1'b0;
    exp = 0;
    for (int i = 0; i < 17; i++) begin
      check("bin_wrap_co", b_co, (exp == 15) ? 1 : 0);
      tick();
      exp = (exp + 1) % 16;
      check("bin_wrap_q", b_q, exp);
    end
    check("bin_wrap_end", b_q, 4'h1);

    // ---- hold then async reset between edges
    b_load = 1'b1; b_d = 4'h6;
    tick();
    check("bin_load6", b_q, 4'h6);
    b_load = 1'b0; b_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_q", b_q, 4'h6);
    end
    check("hold_qbar", b_qbar, 4'h9);
    @(negedge clk);
    b_rst = 1'b1;
    #1;
    check("hold_rst_q",    b_q,    4'h0);
    check("hold_rst_qbar", b_qbar, 4'hf);
    #2;
    b_rst = 1'b0;

    // ---- decade counting
    m_en = 1'b1;
    check("dec_tc0", m_tc, 1'b0);
    exp = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      exp = (exp + 1) % 10;
      check("dec_q",  m_q,  exp);
      check("dec_tc", m_tc, (exp == 9) ? 1 : 0);
    end
    check("dec_wrap0", m_q, 4'h0);

    // ---- out-of-range load, recovers on next count
    m_load = 1'b1; m_d = 4'hc;
    tick();
    check("dec_load12_q",    m_q,    4'hc);
    check("dec_load12_qbar", m_qbar, 4'h3);
    check("dec_load12_tc",   m_tc,   1'b0);
    m_load = 1'b0;
    tick();
    check("dec_recover", m_q, 4'h0);

    // ---- load vs. carry at terminal count
    for (int i = 0; i < 9; i++) tick();
    check("dec_at9_q",  m_q,  4'h9);
    check("dec_at9_co", m_co, 1'b1);
    m_load = 1'b1; m_d = 4'h3;
    #1;
    check("load_vs_co", m_co, 1'b0);
    check("load_vs_tc", m_tc, 1'b1);
    tick();
    check("load_vs_q", m_q, 4'h3);
    m_load = 1'b0; m_en = 1'b0;

    // ---- two-stage cascade, 300 enabled edges
    c_en = 1'b1;
    exp = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      exp = (exp + 1) % 256;
      check("cascade_val", {c_hi_q, c_lo_q}, exp);
    end
    check("cascade_hi", c_hi_q, 4'h2);
    check("cascade_lo", c_lo_q, 4'hc);
    c_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
